if_fetch_unit: RTL and testbench

- Front-end fetch stage. Owns the PC, issues single-outstanding requests to instruction memory, and presents fetched {inst, pc} in a registered output slot to the IF/ID pipeline register.
- Honours the full-stall hold and jump redirects.
- Guarantees that a response to a request from before a redirect never reaches the output slot.

---
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a
// time, and holds the fetched {inst, pc} in a registered slot for IF/ID.
module if_fetch_unit #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INST_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              full_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] jump_pc;
  logic              consumed;
  logic              slot_free;
  logic              load;
  logic              drop;

  assign jump_pc   = jump_target & ~ADDR_W'(3);
  assign consumed  = out_valid && !full_stall;
  assign slot_free = !out_valid || consumed;

  // Request strobe is combinational so a freed slot is refilled in the same cycle.
  assign imem_req  = !rst && (state == ST_ISSUE) && !jump_valid && slot_free;
  assign imem_addr = pc;

  // Next-state and per-cycle load/drop decisions; a jump always wins over a response.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (!jump_valid && slot_free) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (jump_valid) begin
          if (imem_rvalid) begin
            drop       = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_DRAIN;
          end
        end else if (imem_rvalid) begin
          load       = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid) begin
          drop       = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      default: state_next = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ISSUE;
    else     state <= state_next;
  end

  // PC and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
      drop_count  <= '0;
    end else begin
      if (jump_valid)  pc <= jump_pc;
      else if (load)   pc <= pc + ADDR_W'(4);
      if (load)        fetch_count <= fetch_count + CNT_W'(1);
      if (drop)        drop_count  <= drop_count + CNT_W'(1);
    end
  end

  // Output slot: jump flushes it even under stall; stall holds it otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (jump_valid) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_inst  <= imem_rdata;
      out_pc    <= pc;
    end else if (consumed) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-programmable imem responder, scoreboard of
// expected slot contents, a cycle table for start-up and directed corner cases.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        full_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [15:0] fetch_count;
  logic [15:0] drop_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // memory responder state
  int          lat = 1;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  if_fetch_unit #(
    .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0100), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .jump_valid(jump_valid), .jump_target(jump_target),
    .full_stall(full_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .fetch_count(fetch_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle: drive inputs mid-cycle, run the memory model, then score new slot contents.
  task automatic cyc(input logic r, input logic jv, input logic [31:0] jt, input logic fs);
    @(negedge clk);
    rst         = r;
    jump_valid  = jv;
    jump_target = jt;
    full_stall  = fs;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr ^ KEY;
        pend        = 0;
      end
    end
    #1;
    if (imem_req) begin
      pend      = 1;
      pend_cnt  = lat;
      pend_addr = imem_addr;
    end
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out_pc", out_pc, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_out_pc", out_pc, e);
        chk("sb_out_inst", out_inst, e ^ KEY);
      end
    end
    prev_valid = out_valid;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  vec_t vecs[4];

  initial begin
    rst = 1'b1; jump_valid = 1'b0; jump_target = '0; full_stall = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,   1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h104, 1'b1, 32'h100};
    vecs[3] = '{1'b0, 32'h0,   1'b0, 32'h0};

    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_fetch_count", 32'(fetch_count), 32'h0);
    chk("rst_drop_count", 32'(drop_count), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);

    // start-up sequence with 1-cycle memory
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("tbl_imem_req", 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req) chk("tbl_imem_addr", imem_addr, vecs[i].addr);
      chk("tbl_out_valid", 32'(out_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) chk("tbl_out_pc", out_pc, vecs[i].pc);
    end

    // full stall holds the 0x104 slot for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("stall_out_valid", 32'(out_valid), 32'h1);
      chk("stall_out_pc", out_pc, 32'h104);
      chk("stall_out_inst", out_inst, 32'h104 ^ KEY);
      chk("stall_imem_req", 32'(imem_req), 32'h0);
    end
    idle();
    chk("unstall_imem_req", 32'(imem_req), 32'h1);
    chk("unstall_imem_addr", imem_addr, 32'h108);
    idle();
    lat = 3;
    idle();
    chk("fetch_count_3", 32'(fetch_count), 32'h3);

    // jump in WAIT with 3-cycle memory
    exp_q.push_back(32'h2000);
    cyc(1'b0, 1'b1, 32'h2003, 1'b0);
    idle();
    chk("jwait_out_valid", 32'(out_valid), 32'h0);
    chk("drain_imem_req_a", 32'(imem_req), 32'h0);
    idle();
    chk("drain_imem_req_b", 32'(imem_req), 32'h0);
    lat = 1;
    idle();
    chk("jwait_drop_count", 32'(drop_count), 32'h1);
    chk("jwait_imem_req", 32'(imem_req), 32'h1);
    chk("jwait_imem_addr", imem_addr, 32'h2000);
    idle();
    idle();

    // jump and response in the same cycle
    exp_q.push_back(32'h400);
    cyc(1'b0, 1'b1, 32'h400, 1'b0);
    idle();
    chk("jrv_out_valid", 32'(out_valid), 32'h0);
    chk("jrv_drop_count", 32'(drop_count), 32'h2);
    chk("jrv_imem_req", 32'(imem_req), 32'h1);
    chk("jrv_imem_addr", imem_addr, 32'h400);
    idle();
    lat = 4;
    idle();

    // two jumps while draining
    exp_q.push_back(32'h600);
    cyc(1'b0, 1'b1, 32'h500, 1'b0);
    cyc(1'b0, 1'b1, 32'h600, 1'b0);
    chk("dj_imem_req_a", 32'(imem_req), 32'h0);
    idle();
    chk("dj_imem_req_b", 32'(imem_req), 32'h0);
    idle();
    chk("dj_imem_req_c", 32'(imem_req), 32'h0);
    lat = 1;
    idle();
    chk("dj_drop_count", 32'(drop_count), 32'h3);
    chk("dj_imem_req", 32'(imem_req), 32'h1);
    chk("dj_imem_addr", imem_addr, 32'h600);
    idle();

    // jump beats stall on a valid slot
    exp_q.push_back(32'h700);
    cyc(1'b0, 1'b1, 32'h700, 1'b1);
    chk("js_imem_req", 32'(imem_req), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("js_out_valid", 32'(out_valid), 32'h0);
    chk("js_out_pc", out_pc, 32'h0);
    chk("js_out_inst", out_inst, 32'h0);
    chk("js_imem_req", 32'(imem_req), 32'h1);
    chk("js_imem_addr", imem_addr, 32'h700);
    idle();

    // PC wrap past 0xFFFF_FFFC
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    idle();
    chk("wrap_imem_addr_a", imem_addr, 32'hFFFF_FFFC);
    idle();
    idle();
    chk("wrap_imem_req", 32'(imem_req), 32'h1);
    chk("wrap_imem_addr_b", imem_addr, 32'h0);
    idle();
    lat = 3;
    idle();
    chk("wrap_fetch_count", 32'(fetch_count), 32'h9);

    // reset while waiting; the late response lands in ISSUE
    exp_q.push_back(32'h100);
    idle();
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    chk("mrst_imem_req", 32'(imem_req), 32'h0);
    chk("mrst_fetch_count", 32'(fetch_count), 32'h0);
    lat = 1;
    idle();
    chk("mrst_imem_req_rel", 32'(imem_req), 32'h1);
    chk("mrst_imem_addr", imem_addr, 32'h100);
    idle();
    chk("mrst_fetch_count_b", 32'(fetch_count), 32'h0);
    chk("mrst_drop_count", 32'(drop_count), 32'h0);
    idle();
    chk("mrst_fetch_count_c", 32'(fetch_count), 32'h1);
    chk("mrst_out_pc", out_pc, 32'h100);

    chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
